// File: rtl/multi_bank_register_file.sv
// Multi-bank physical register file: per-register pending bits, writeback bypass/snoop and an init-clear sweep.
// Build option: define RF_ZERO_ON_INIT_EN to also zero every bank entry while the sweep runs.
module multi_bank_register_file #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 64,
    parameter int NUM_READ_PORTS = 2,
    parameter int NUM_WB_GROUPS  = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int GW = (NUM_WB_GROUPS > 1) ? $clog2(NUM_WB_GROUPS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 init_req,
    output logic                                 ready,
    output logic                                 state_dbg,
    input  logic                                 decode_advance,
    input  logic [NUM_READ_PORTS*AW-1:0]         decode_rs_addr,
    input  logic [NUM_READ_PORTS*GW-1:0]         decode_rs_group,
    input  logic                                 decode_uses_rd,
    input  logic [AW-1:0]                        decode_rd_addr,
    input  logic                                 flush,
    output logic [NUM_READ_PORTS-1:0]            issue_inuse,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] issue_data,
    input  logic [NUM_WB_GROUPS-1:0]             wb_valid,
    input  logic [NUM_WB_GROUPS*AW-1:0]          wb_addr,
    input  logic [NUM_WB_GROUPS*DATA_WIDTH-1:0]  wb_data
);

    // Handshake: decode_advance is a transfer only while ready=1 (it is dropped during the sweep);
    // wb_valid[g] is a fire-and-forget strobe with no back-pressure, also dropped while ready=0.
    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t                state, state_nxt;
    logic [AW-1:0]         idx, idx_nxt;
    logic [DEPTH-1:0]      pending, pending_nxt;
    logic [DATA_WIDTH-1:0] bank [NUM_WB_GROUPS][DEPTH];
    logic                  alloc;

    logic [AW-1:0]         wb_addr_a [NUM_WB_GROUPS];
    logic [DATA_WIDTH-1:0] wb_data_a [NUM_WB_GROUPS];
    logic [AW-1:0]         rs_addr_a [NUM_READ_PORTS];
    logic [GW-1:0]         rs_grp_a  [NUM_READ_PORTS];

    logic [AW-1:0]             held_addr [NUM_READ_PORTS];
    logic [AW-1:0]             held_addr_nxt [NUM_READ_PORTS];
    logic [GW-1:0]             held_grp [NUM_READ_PORTS];
    logic [GW-1:0]             held_grp_nxt [NUM_READ_PORTS];
    logic [DATA_WIDTH-1:0]     data_q [NUM_READ_PORTS];
    logic [DATA_WIDTH-1:0]     data_nxt [NUM_READ_PORTS];
    logic [NUM_READ_PORTS-1:0] inuse_nxt;

    for (genvar g = 0; g < NUM_WB_GROUPS; g++) begin : g_wb_unpack
        assign wb_addr_a[g] = wb_addr[g*AW +: AW];
        assign wb_data_a[g] = wb_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port_unpack
        assign rs_addr_a[p] = decode_rs_addr[p*AW +: AW];
        assign rs_grp_a[p]  = decode_rs_group[p*GW +: GW];
        assign issue_data[p*DATA_WIDTH +: DATA_WIDTH] = data_q[p];
    end

    assign ready     = (state == READY);
    assign state_dbg = state;
    assign alloc     = (state == READY) && decode_advance && decode_uses_rd &&
                       (decode_rd_addr != '0) && !flush;

    // Group selects loop over real groups so an out-of-range group id simply never matches.
    function automatic logic wb_hit(input logic [GW-1:0] g, input logic [AW-1:0] a);
        wb_hit = 1'b0;
        for (int i = 0; i < NUM_WB_GROUPS; i++)
            if (GW'(i) == g && wb_valid[i] && wb_addr_a[i] == a) wb_hit = 1'b1;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] wb_pick(input logic [GW-1:0] g);
        wb_pick = '0;
        for (int i = 0; i < NUM_WB_GROUPS; i++)
            if (GW'(i) == g) wb_pick = wb_data_a[i];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] bank_rd(input logic [GW-1:0] g, input logic [AW-1:0] a);
        bank_rd = '0;
        for (int i = 0; i < NUM_WB_GROUPS; i++)
            if (GW'(i) == g) bank_rd = bank[i][a];
    endfunction

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (state == CLEAR) begin
            if (init_req) begin
                idx_nxt = '0;
            end else if (idx == AW'(DEPTH - 1)) begin
                state_nxt = READY;
                idx_nxt   = '0;
            end else begin
                idx_nxt = idx + AW'(1);
            end
        end else if (init_req) begin
            state_nxt = CLEAR;
            idx_nxt   = '0;
        end
    end

    // Allocation is applied after the writeback clears so a same-cycle set wins.
    always_comb begin
        pending_nxt = pending;
        if (state == CLEAR) begin
            pending_nxt[idx] = 1'b0;
        end else begin
            for (int g = 0; g < NUM_WB_GROUPS; g++)
                if (wb_valid[g]) pending_nxt[wb_addr_a[g]] = 1'b0;
            if (alloc) pending_nxt[decode_rd_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_comb begin
        inuse_nxt     = issue_inuse;
        data_nxt      = data_q;
        held_addr_nxt = held_addr;
        held_grp_nxt  = held_grp;
        if (state == READY) begin
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                if (decode_advance) begin
                    held_addr_nxt[p] = rs_addr_a[p];
                    held_grp_nxt[p]  = rs_grp_a[p];
                    if (rs_addr_a[p] == '0) begin
                        data_nxt[p]  = '0;
                        inuse_nxt[p] = 1'b0;
                    end else if (wb_hit(rs_grp_a[p], rs_addr_a[p])) begin
                        data_nxt[p]  = wb_pick(rs_grp_a[p]);
                        inuse_nxt[p] = 1'b0;
                    end else begin
                        data_nxt[p]  = bank_rd(rs_grp_a[p], rs_addr_a[p]);
                        inuse_nxt[p] = pending[rs_addr_a[p]];
                    end
                end else if (issue_inuse[p] && wb_hit(held_grp[p], held_addr[p])) begin
                    data_nxt[p]  = wb_pick(held_grp[p]);
                    inuse_nxt[p] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= CLEAR;
            idx         <= '0;
            pending     <= '0;
            issue_inuse <= '0;
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                data_q[p]    <= '0;
                held_addr[p] <= '0;
                held_grp[p]  <= '0;
            end
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            pending     <= pending_nxt;
            issue_inuse <= inuse_nxt;
            data_q      <= data_nxt;
            held_addr   <= held_addr_nxt;
            held_grp    <= held_grp_nxt;
        end
    end

    // Banks carry no reset so they can map onto plain RAM when the zeroing sweep is disabled.
    always_ff @(posedge clk) begin
        for (int g = 0; g < NUM_WB_GROUPS; g++) begin
            if (state == READY && wb_valid[g] && wb_addr_a[g] != '0)
                bank[g][wb_addr_a[g]] <= wb_data_a[g];
`ifdef RF_ZERO_ON_INIT_EN
            else if (state == CLEAR)
                bank[g][idx] <= '0;
`endif
        end
    end

    for (genvar i = 0; i < NUM_WB_GROUPS; i++) begin : g_wb_chk
        for (genvar j = i + 1; j < NUM_WB_GROUPS; j++) begin : g_pair
            a_wb_unique: assert property (@(posedge clk) disable iff (!rst)
                !(state == READY && wb_valid[i] && wb_valid[j] &&
                  wb_addr_a[i] != '0 && wb_addr_a[i] == wb_addr_a[j]));
        end
    end

endmodule

// File: tb/tb_multi_bank_register_file.sv
// Bench for multi_bank_register_file: directed vector table, init-sweep sequences and random traffic
// against a behavioural model (model follows RF_ZERO_ON_INIT_EN the same way as the design).
module tb_multi_bank_register_file;

    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int NP    = 2;
    localparam int NG    = 2;
    localparam int AW    = 6;
    localparam int GW    = 1;
    localparam int EW    = 2*DW + 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             init_req = 1'b0;
    logic             ready;
    logic             state_dbg;
    logic             decode_advance = 1'b0;
    logic [NP*AW-1:0] decode_rs_addr = '0;
    logic [NP*GW-1:0] decode_rs_group = '0;
    logic             decode_uses_rd = 1'b0;
    logic [AW-1:0]    decode_rd_addr = '0;
    logic             flush = 1'b0;
    logic [NP-1:0]    issue_inuse;
    logic [NP*DW-1:0] issue_data;
    logic [NG-1:0]    wb_valid = '0;
    logic [NG*AW-1:0] wb_addr = '0;
    logic [NG*DW-1:0] wb_data = '0;

    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];

    multi_bank_register_file #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_READ_PORTS(NP), .NUM_WB_GROUPS(NG)
    ) dut (
        .clk(clk), .rst(rst), .init_req(init_req), .ready(ready), .state_dbg(state_dbg),
        .decode_advance(decode_advance), .decode_rs_addr(decode_rs_addr),
        .decode_rs_group(decode_rs_group), .decode_uses_rd(decode_uses_rd),
        .decode_rd_addr(decode_rd_addr), .flush(flush), .issue_inuse(issue_inuse),
        .issue_data(issue_data), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // Behavioural model: sweep is a countdown; entering the sweep wipes pending (and banks if zeroing)
    int               m_left;
    logic [DW-1:0]    m_bank  [NG][DEPTH];
    bit               m_known [NG][DEPTH];
    bit               m_pend  [DEPTH];
    bit               m_inuse [NP];
    logic [DW-1:0]    m_data  [NP];
    bit               m_dk    [NP];
    int               m_haddr [NP];
    int               m_hgrp  [NP];

    function automatic int in_rs(input int p);
        return int'(decode_rs_addr[p*AW +: AW]);
    endfunction

    function automatic int in_rg(input int p);
        return int'(decode_rs_group[p*GW +: GW]);
    endfunction

    function automatic int in_wa(input int g);
        return int'(wb_addr[g*AW +: AW]);
    endfunction

    function automatic logic [DW-1:0] in_wd(input int g);
        return wb_data[g*DW +: DW];
    endfunction

    function automatic bit m_hit(input int g, input int a);
        return (g < NG) && wb_valid[g] && (in_wa(g) == a);
    endfunction

    task automatic model_enter_clear();
        m_left = DEPTH;
        for (int a = 0; a < DEPTH; a++) m_pend[a] = 1'b0;
`ifdef RF_ZERO_ON_INIT_EN
        for (int g = 0; g < NG; g++)
            for (int a = 0; a < DEPTH; a++) begin
                m_bank[g][a]  = '0;
                m_known[g][a] = 1'b1;
            end
`endif
    endtask

    task automatic model_reset();
        for (int g = 0; g < NG; g++)
            for (int a = 0; a < DEPTH; a++) m_known[g][a] = 1'b0;
        for (int p = 0; p < NP; p++) begin
            m_inuse[p] = 1'b0;
            m_data[p]  = '0;
            m_dk[p]    = 1'b1;
            m_haddr[p] = 0;
            m_hgrp[p]  = 0;
        end
        model_enter_clear();
    endtask

    task automatic model_step();
        int a;
        int g;
        if (m_left > 0) begin
            m_left = init_req ? DEPTH : m_left - 1;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (decode_advance) begin
                    a = in_rs(p);
                    g = in_rg(p);
                    m_haddr[p] = a;
                    m_hgrp[p]  = g;
                    if (a == 0) begin
                        m_data[p] = '0; m_inuse[p] = 1'b0; m_dk[p] = 1'b1;
                    end else if (m_hit(g, a)) begin
                        m_data[p] = in_wd(g); m_inuse[p] = 1'b0; m_dk[p] = 1'b1;
                    end else begin
                        m_data[p] = m_bank[g][a]; m_inuse[p] = m_pend[a]; m_dk[p] = m_known[g][a];
                    end
                end else if (m_inuse[p] && m_hit(m_hgrp[p], m_haddr[p])) begin
                    m_data[p] = in_wd(m_hgrp[p]); m_inuse[p] = 1'b0; m_dk[p] = 1'b1;
                end
            end
            for (int w = 0; w < NG; w++) begin
                if (wb_valid[w]) begin
                    m_pend[in_wa(w)] = 1'b0;
                    if (in_wa(w) != 0) begin
                        m_bank[w][in_wa(w)]  = in_wd(w);
                        m_known[w][in_wa(w)] = 1'b1;
                    end
                end
            end
            if (decode_advance && decode_uses_rd && !flush && decode_rd_addr != '0)
                m_pend[int'(decode_rd_addr)] = 1'b1;
            if (init_req) model_enter_clear();
        end
    endtask

    function automatic logic [EW-1:0] model_word();
        return {m_dk[1], m_dk[0], (m_left == 0), m_inuse[1], m_inuse[0], m_data[1], m_data[0]};
    endfunction

    // Driver tasks
    task automatic idle_inputs();
        init_req        = 1'b0;
        decode_advance  = 1'b0;
        decode_rs_addr  = '0;
        decode_rs_group = '0;
        decode_uses_rd  = 1'b0;
        decode_rd_addr  = '0;
        flush           = 1'b0;
        wb_valid        = '0;
        wb_addr         = '0;
        wb_data         = '0;
    endtask

    task automatic set_rs(input int p, input int a, input int g);
        decode_rs_addr[p*AW +: AW]  = AW'(a);
        decode_rs_group[p*GW +: GW] = GW'(g);
    endtask

    task automatic set_wb(input int g, input int a, input logic [DW-1:0] d);
        wb_valid[g]          = 1'b1;
        wb_addr[g*AW +: AW]  = AW'(a);
        wb_data[g*DW +: DW]  = d;
    endtask

    task automatic drive_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic compare_pop(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".ready"},     DW'(ready),          DW'(e[2*DW+2]));
        check({tag, ".state_dbg"}, DW'(state_dbg),      DW'(e[2*DW+2]));
        check({tag, ".inuse0"},    DW'(issue_inuse[0]), DW'(e[2*DW]));
        check({tag, ".inuse1"},    DW'(issue_inuse[1]), DW'(e[2*DW+1]));
        if (e[2*DW+3]) check({tag, ".data0"}, issue_data[DW-1:0],    e[DW-1:0]);
        if (e[2*DW+4]) check({tag, ".data1"}, issue_data[2*DW-1:DW], e[2*DW-1:DW]);
    endtask

    task automatic check_vs_model(input string tag);
        exp_q.push_back(model_word());
        compare_pop(tag);
    endtask

    typedef struct {
        int          adv, urd, fl, rd;
        int          rs0, g0, rs1, g1;
        bit [1:0]    wbv;
        int          wa0;
        logic [31:0] wd0;
        int          wa1;
        logic [31:0] wd1;
        bit [1:0]    e_inuse;
        bit [1:0]    e_mask;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int n;
        logic [DW-1:0] exp3;

        // adv urd fl rd | rs0 g0 rs1 g1 | wbv wa0 wd0 wa1 wd1 | e_inuse e_mask e_d0 e_d1
        vecs[0]  = '{1,1,0,5,  0,0,0,0,  2'b00, 0,32'h0,       0,32'h0,        2'b00,2'b11,32'h0,       32'h0};
        vecs[1]  = '{1,0,0,0,  5,1,0,0,  2'b00, 0,32'h0,       0,32'h0,        2'b01,2'b10,32'h0,       32'h0};
        vecs[2]  = '{0,0,0,0,  0,0,0,0,  2'b10, 0,32'h0,       5,32'hDEADBEEF, 2'b00,2'b11,32'hDEADBEEF,32'h0};
        vecs[3]  = '{1,0,0,0,  0,0,9,0,  2'b01, 9,32'h1234,    0,32'h0,        2'b00,2'b11,32'h0,       32'h1234};
        vecs[4]  = '{1,1,1,7,  0,0,0,0,  2'b01, 7,32'h77,      0,32'h0,        2'b00,2'b11,32'h0,       32'h0};
        vecs[5]  = '{1,0,0,0,  7,0,0,0,  2'b00, 0,32'h0,       0,32'h0,        2'b00,2'b11,32'h77,      32'h0};
        vecs[6]  = '{1,1,0,0,  0,0,0,0,  2'b00, 0,32'h0,       0,32'h0,        2'b00,2'b11,32'h0,       32'h0};
        vecs[7]  = '{1,0,0,0,  0,1,0,0,  2'b01, 0,32'hAAAA,    0,32'h0,        2'b00,2'b11,32'h0,       32'h0};
        vecs[8]  = '{1,1,0,12, 0,0,0,0,  2'b01, 12,32'hC0C0,   0,32'h0,        2'b00,2'b11,32'h0,       32'h0};
        vecs[9]  = '{1,0,0,0,  12,0,0,0, 2'b00, 0,32'h0,       0,32'h0,        2'b01,2'b10,32'h0,       32'h0};
        vecs[10] = '{0,0,0,0,  0,0,0,0,  2'b10, 0,32'h0,       12,32'h55,      2'b01,2'b10,32'h0,       32'h0};
        vecs[11] = '{0,0,0,0,  0,0,0,0,  2'b01, 12,32'h66,     0,32'h0,        2'b00,2'b11,32'h66,      32'h0};
        vecs[12] = '{1,0,0,0,  12,0,0,0, 2'b00, 0,32'h0,       0,32'h0,        2'b00,2'b11,32'h66,      32'h0};
        vecs[13] = '{1,0,0,0,  12,1,5,1, 2'b00, 0,32'h0,       0,32'h0,        2'b00,2'b11,32'h55,      32'hDEADBEEF};

        // Reset: outputs quiet while held, then ready rises after exactly DEPTH sweep cycles
        idle_inputs();
        #2 rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst.ready", DW'(ready), '0);
            check("rst.inuse", DW'(issue_inuse), '0);
            check("rst.data0", issue_data[DW-1:0], '0);
            check("rst.data1", issue_data[2*DW-1:DW], '0);
        end
        rst = 1'b1;
        model_reset();
        n = 0;
        while (!ready && n < 200) begin
            drive_cycle();
            check_vs_model("sweep");
            n++;
        end
        check("reset_sweep_len", DW'(n), DW'(DEPTH));

        // Fill both banks with random contents (groups never share an address in a cycle)
        for (int i = 0; i < DEPTH; i++) begin
            idle_inputs();
            if (i != 0) set_wb(0, i, $urandom);
            if (i != DEPTH - 1) set_wb(1, i + 1, $urandom);
            drive_cycle();
            check_vs_model("fill");
        end

        // Directed vector table
        for (int v = 0; v < 14; v++) begin
            idle_inputs();
            decode_advance = (vecs[v].adv != 0);
            decode_uses_rd = (vecs[v].urd != 0);
            flush          = (vecs[v].fl != 0);
            decode_rd_addr = AW'(vecs[v].rd);
            set_rs(0, vecs[v].rs0, vecs[v].g0);
            set_rs(1, vecs[v].rs1, vecs[v].g1);
            if (vecs[v].wbv[0]) set_wb(0, vecs[v].wa0, vecs[v].wd0);
            if (vecs[v].wbv[1]) set_wb(1, vecs[v].wa1, vecs[v].wd1);
            drive_cycle();
            exp_q.push_back({vecs[v].e_mask[1], vecs[v].e_mask[0], 1'b1,
                             vecs[v].e_inuse[1], vecs[v].e_inuse[0], vecs[v].e_d1, vecs[v].e_d0});
            compare_pop($sformatf("vec%0d", v));
        end

        // Init sweep: traffic during the sweep is ignored, pending is wiped, bank zeroing per build
        idle_inputs();
        set_wb(0, 3, 32'hFF);
        decode_advance = 1'b1;
        decode_uses_rd = 1'b1;
        decode_rd_addr = AW'(20);
        drive_cycle();
        check_vs_model("pre_init");
        idle_inputs();
        init_req = 1'b1;
        drive_cycle();
        check_vs_model("init_pulse");
        n = 0;
        while (!ready && n < 200) begin
            idle_inputs();
            if (n == 5) begin
                decode_advance = 1'b1;
                set_rs(0, 3, 0);
                set_wb(0, 3, 32'hAB);
            end
            drive_cycle();
            check_vs_model("init_sweep");
            n++;
        end
        check("init_sweep_len", DW'(n), DW'(DEPTH));
        idle_inputs();
        decode_advance = 1'b1;
        set_rs(0, 3, 0);
        set_rs(1, 20, 0);
        drive_cycle();
        check_vs_model("post_init");
`ifdef RF_ZERO_ON_INIT_EN
        exp3 = '0;
`else
        exp3 = 32'hFF;
`endif
        check("post_init_rs3", issue_data[DW-1:0], exp3);
        check("post_init_rd20_inuse", DW'(issue_inuse[1]), '0);

        // init_req in the middle of a sweep restarts the full count
        idle_inputs();
        init_req = 1'b1;
        drive_cycle();
        check_vs_model("restart_pulse");
        repeat (10) begin
            idle_inputs();
            drive_cycle();
            check_vs_model("restart_a");
        end
        idle_inputs();
        init_req = 1'b1;
        drive_cycle();
        check_vs_model("restart_mid");
        n = 0;
        while (!ready && n < 200) begin
            idle_inputs();
            drive_cycle();
            check_vs_model("restart_sweep");
            n++;
        end
        check("restart_sweep_len", DW'(n), DW'(DEPTH));

        // Random traffic concentrated on low addresses to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            idle_inputs();
            decode_advance = ($urandom_range(0, 1) == 1);
            decode_uses_rd = ($urandom_range(0, 3) != 0);
            decode_rd_addr = AW'($urandom_range(0, 15));
            flush          = ($urandom_range(0, 4) == 0);
            for (int p = 0; p < NP; p++)
                set_rs(p, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
            for (int g = 0; g < NG; g++)
                if ($urandom_range(0, 2) == 0) set_wb(g, int'($urandom_range(0, 15)), $urandom);
            if (wb_valid == 2'b11 && wb_addr[AW-1:0] == wb_addr[2*AW-1:AW]) wb_valid[1] = 1'b0;
            init_req = ($urandom_range(0, 299) == 0);
            drive_cycle();
            check_vs_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
